// File: rtl/pe_inject_ctrl.sv
// ============================================================================
// Module   : pe_inject_ctrl
// Purpose  : Buffers neuron PE flits, stamps source coordinates, injects into
//            the XY switch when it is free and flags prolonged starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_inject_ctrl #(
    parameter int                x_size       = 2,
    parameter int                y_size       = 2,
    parameter int                data_width   = 8,
    parameter logic [x_size-1:0] x_coord      = '0,
    parameter logic [y_size-1:0] y_coord      = '0,
    parameter int                total_width  = 2*x_size + 2*y_size + data_width,
    parameter int                DEPTH        = 4,
    parameter int                STARVE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid_nn,
    input  logic [total_width-1:0]     i_data_nn,
    output logic                       o_ready_nn,
    input  logic                       i_ready_sw,
    output logic                       o_valid_sw,
    output logic [total_width-1:0]     o_data_sw,
    output logic                       o_starve,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [15:0]                o_inj_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
    localparam logic [BW-1:0] c_limit     = BW'(STARVE_LIMIT);
    localparam logic [BW-1:0] c_limit_m1  = BW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        STARVED = 2'd2
    } state_t;

    logic [total_width-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic [BW-1:0]          r_blk;
    logic [15:0]            r_inj_cnt;
    logic                   r_starve;
    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_blocked;
    logic                   w_last_out;
    logic [total_width-1:0] w_stamped;

    assign o_ready_nn = (r_count < c_depth);
    assign o_valid_sw = (r_count != '0);
    assign o_data_sw  = o_valid_sw ? r_mem[r_rptr] : '0;
    assign o_count    = r_count;
    assign o_inj_cnt  = r_inj_cnt;
    assign o_starve   = r_starve;

    assign w_push     = i_valid_nn & o_ready_nn;
    assign w_pop      = o_valid_sw & i_ready_sw;
    assign w_blocked  = o_valid_sw & ~i_ready_sw;
    // Pop of the only entry with nothing arriving behind it.
    assign w_last_out = w_pop & ~w_push & (r_count == CW'(1));

    assign w_stamped = {i_data_nn[total_width-1 -: data_width], x_coord, y_coord,
                        i_data_nn[x_size+y_size-1:0]};

    // Storage is not reset; o_data_sw is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_stamped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_blk     <= '0;
            r_inj_cnt <= '0;
            r_starve  <= 1'b0;
            r_state   <= IDLE;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) r_inj_cnt <= r_inj_cnt + 16'd1;
            if (w_pop || !o_valid_sw) begin
                r_blk <= '0;
            end else if (w_blocked && r_blk != c_limit) begin
                r_blk <= r_blk + BW'(1);
            end
            r_state  <= w_state_next;
            r_starve <= (w_state_next == STARVED);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_push) w_state_next = SEND;
            end
            SEND: begin
                if (w_last_out) begin
                    w_state_next = IDLE;
                end else if (w_blocked && r_blk == c_limit_m1) begin
                    w_state_next = STARVED;
                end
            end
            STARVED: begin
                if (w_pop) w_state_next = w_last_out ? IDLE : SEND;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_inject_ctrl.sv
// ============================================================================
// Module   : tb_pe_inject_ctrl
// Purpose  : Directed self-checking bench for pe_inject_ctrl (node X=2, Y=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_inject_ctrl;

    logic        clk;
    logic        rst;
    logic        i_valid_nn;
    logic [15:0] i_data_nn;
    logic        o_ready_nn;
    logic        i_ready_sw;
    logic        o_valid_sw;
    logic [15:0] o_data_sw;
    logic        o_starve;
    logic [2:0]  o_count;
    logic [15:0] o_inj_cnt;

    int total;
    int bad;

    pe_inject_ctrl #(
        .x_size(2), .y_size(2), .data_width(8),
        .x_coord(2'd2), .y_coord(2'd1),
        .DEPTH(4), .STARVE_LIMIT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid_nn(i_valid_nn), .i_data_nn(i_data_nn), .o_ready_nn(o_ready_nn),
        .i_ready_sw(i_ready_sw), .o_valid_sw(o_valid_sw), .o_data_sw(o_data_sw),
        .o_starve(o_starve), .o_count(o_count), .o_inj_cnt(o_inj_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        i_valid_nn = 1'b0;
        i_data_nn = '0;
        i_ready_sw = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(o_valid_sw), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_starve", 32'(o_starve), 32'd0);
        chk("rst_inj", 32'(o_inj_cnt), 32'd0);
        chk("rst_data", 32'(o_data_sw), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_ready", 32'(o_ready_nn), 32'd1);

        // Single flit: src field 11/11 replaced by 10/01.
        i_ready_sw = 1'b1;
        i_valid_nn = 1'b1;
        i_data_nn  = 16'hA5F6;
        step();
        i_valid_nn = 1'b0;
        chk("single_valid", 32'(o_valid_sw), 32'd1);
        chk("single_data", 32'(o_data_sw), 32'h0000_A596);
        step();
        chk("single_inj", 32'(o_inj_cnt), 32'd1);
        chk("single_empty", 32'(o_count), 32'd0);
        chk("single_novalid", 32'(o_valid_sw), 32'd0);

        // Fill to full while blocked; low byte 05 stamps to 95.
        i_ready_sw = 1'b0;
        i_valid_nn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data_nn = {8'h10 + 8'(i), 8'h05};
            step();
        end
        i_data_nn = 16'h1405;
        chk("full_count", 32'(o_count), 32'd4);
        chk("full_ready", 32'(o_ready_nn), 32'd0);
        step();
        chk("full_hold", 32'(o_count), 32'd4);
        i_valid_nn = 1'b0;
        i_ready_sw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(o_data_sw), 32'({8'h10 + 8'(i), 8'h95}));
            step();
        end
        chk("drain_empty", 32'(o_valid_sw), 32'd0);
        chk("drain_inj", 32'(o_inj_cnt), 32'd5);

        // Concurrent push/pop at occupancy 2.
        i_ready_sw = 1'b0;
        i_valid_nn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_data_nn = {8'hE0 + 8'(i), 8'h0A};
            step();
        end
        chk("pp_pre_count", 32'(o_count), 32'd2);
        i_ready_sw = 1'b1;
        for (int i = 2; i < 5; i++) begin
            i_data_nn = {8'hE0 + 8'(i), 8'h0A};
            chk("pp_head", 32'(o_data_sw), 32'({8'hE0 + 8'(i - 2), 8'h9A}));
            step();
            chk("pp_count", 32'(o_count), 32'd2);
        end
        i_valid_nn = 1'b0;
        for (int i = 3; i < 5; i++) begin
            chk("pp_tail", 32'(o_data_sw), 32'({8'hE0 + 8'(i), 8'h9A}));
            step();
        end
        chk("pp_empty", 32'(o_count), 32'd0);
        chk("pp_inj", 32'(o_inj_cnt), 32'd10);

        // Starvation after 16 blocked cycles.
        i_ready_sw = 1'b0;
        i_valid_nn = 1'b1;
        i_data_nn  = 16'h7733;
        step();
        i_valid_nn = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("starve_15", 32'(o_starve), 32'd0);
        step();
        chk("starve_16", 32'(o_starve), 32'd1);
        step();
        chk("starve_hold", 32'(o_starve), 32'd1);
        i_ready_sw = 1'b1;
        step();
        chk("starve_clear", 32'(o_starve), 32'd0);
        chk("starve_empty", 32'(o_count), 32'd0);
        chk("starve_inj", 32'(o_inj_cnt), 32'd11);

        // Injection counter wraps.
        force dut.r_inj_cnt = 16'hFFFF;
        #1;
        release dut.r_inj_cnt;
        i_valid_nn = 1'b1;
        i_data_nn  = 16'h0101;
        step();
        i_valid_nn = 1'b0;
        step();
        chk("inj_wrap", 32'(o_inj_cnt), 32'd0);

        // Asynchronous reset with 3 flits buffered and starved.
        i_ready_sw = 1'b0;
        i_valid_nn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data_nn = {8'hC0 + 8'(i), 8'h00};
            step();
        end
        i_valid_nn = 1'b0;
        for (int i = 0; i < 18; i++) step();
        chk("ar_pre_starve", 32'(o_starve), 32'd1);
        chk("ar_pre_count", 32'(o_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(o_valid_sw), 32'd0);
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_starve", 32'(o_starve), 32'd0);
        rst = 1'b0;
        step();
        chk("ar_ready", 32'(o_ready_nn), 32'd1);
        chk("ar_still_empty", 32'(o_valid_sw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
